// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioning block.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned BTN_N                = 4;
    localparam int unsigned BTN_DEBOUNCE_DEFAULT = 100000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser chain, debounce FSM and stability counter.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    btn_state_t             state;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], btn};
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state <= HELD;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= HELD;
                    end else if (cnt == LAST) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_strobe.sv
// Debounced button levels/pulses plus a one-hot digit load select for the hex display.
module btn_debounce_strobe
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = BTN_N,
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             load_valid,
    output logic [N_BTN-1:0] load_sel,
    output logic             any_held
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .btn          (btn[i]),
            .level        (btn_level[i]),
            .press        (btn_press[i]),
            .release_pulse(btn_release[i])
        );
    end

    // Decoded purely from the registered press pulses so it lines up with btn_press.
    always_comb begin
        logic found;
        found    = 1'b0;
        load_sel = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (btn_press[i] && !found) begin
                load_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign load_valid = |btn_press;
    assign any_held   = |btn_level;

endmodule

// File: tb/tb_btn_debounce_strobe.sv
// Randomised and directed bench for btn_debounce_strobe against a run-length reference model.
module tb_btn_debounce_strobe;

    localparam int N = 4;
    localparam int D = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, load_sel;
    logic         load_valid, any_held;

    always #5 clk = ~clk;

    btn_debounce_strobe #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .load_valid (load_valid),
        .load_sel   (load_sel),
        .any_held   (any_held)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: s is btn delayed S edges; a level flips once s has differed from it for D+1 samples.
    logic [N-1:0] m_hist [S];
    logic [N-1:0] m_level, m_press, m_rel;
    int           m_run [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic r);
        logic [N-1:0] s;
        if (r) begin
            for (int k = 0; k < S; k++) m_hist[k] = '0;
            m_level = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            s = m_hist[S-1];
            m_press = '0; m_rel = '0;
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_level[i] = s[i];
                        if (s[i]) m_press[i] = 1'b1;
                        else      m_rel[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = b;
        end
    endtask

    task automatic step(input logic [N-1:0] b, input logic r);
        logic [N-1:0] exp_sel;
        @(negedge clk);
        btn = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        exp_sel = m_press & (~m_press + 1'b1);
        check_eq("level",   32'(btn_level),   32'(m_level));
        check_eq("press",   32'(btn_press),   32'(m_press));
        check_eq("release", 32'(btn_release), 32'(m_rel));
        check_eq("load_valid", 32'(load_valid), 32'(|m_press));
        check_eq("load_sel",   32'(load_sel),   32'(exp_sel));
        check_eq("any_held",   32'(any_held),   32'(|m_level));
    endtask

    initial begin
        int lat;
        int pulses;
        int run_left [N];
        logic [N-1:0] b;

        // Reset with btn idle.
        step('0, 1'b1);
        step('0, 1'b1);
        check_eq("reset_level", 32'(btn_level), 32'h0);
        check_eq("reset_sel",   32'(load_sel),  32'h0);

        // Single press on btn[0]: first capture is edge 0, pulse after edge S+D.
        lat = -1;
        for (int i = 0; i < 14; i++) begin
            step(4'b0001, 1'b0);
            if (btn_press[0] && lat < 0) lat = i;
        end
        check_eq("press_latency", 32'(lat), 32'(S + D));
        check_eq("held_level0",   32'(btn_level), 32'b0001);

        // Bounce on btn[1], then a stable press.
        for (int i = 0; i < 5; i++)  step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        for (int i = 0; i < 5; i++)  step(4'b0011, 1'b0);
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);
        check_eq("bounce_level", 32'(btn_level), 32'b0001);
        for (int i = 0; i < 14; i++) step(4'b0011, 1'b0);
        check_eq("press1_level", 32'(btn_level), 32'b0011);

        // Release btn[0] with a 3-cycle glitch high mid-wait.
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0011, 1'b0);
        lat = -1;
        for (int i = 0; i < 14; i++) begin
            step(4'b0010, 1'b0);
            if (btn_release[0] && lat < 0) lat = i;
        end
        check_eq("release_latency", 32'(lat), 32'(S + D));

        // Simultaneous press on channels 1 and 3 from idle.
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(4'b1010, 1'b0);
            if (load_valid) check_eq("sim_sel", 32'(load_sel), 32'b0010);
        end
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0);

        // Reset in the middle of a hold on btn[2].
        for (int i = 0; i < 14; i++) step(4'b0100, 1'b0);
        check_eq("pre_rst_level", 32'(btn_level), 32'b0100);
        step(4'b0100, 1'b1);
        check_eq("rst_release", 32'(btn_release), 32'h0);
        lat = -1;
        for (int i = 0; i < 14; i++) begin
            step(4'b0100, 1'b0);
            if (btn_press[2] && lat < 0) lat = i;
        end
        check_eq("rst_repress_latency", 32'(lat), 32'(S + D));

        // Stress: every bit toggles after 1..7 cycles, so nothing may be accepted.
        step('0, 1'b1);
        b = '0;
        for (int i = 0; i < N; i++) run_left[i] = $urandom_range(1, 7);
        pulses = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                run_left[i]--;
                if (run_left[i] == 0) begin
                    b[i] = ~b[i];
                    run_left[i] = $urandom_range(1, 7);
                end
            end
            step(b, 1'b0);
            if (btn_press != '0 || btn_release != '0) pulses++;
        end
        check_eq("stress_pulses", 32'(pulses), 32'h0);
        check_eq("stress_level",  32'(btn_level), 32'h0);

        // Random mix of short glitches and long holds, with occasional reset.
        for (int i = 0; i < N; i++) run_left[i] = $urandom_range(1, 20);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                run_left[i]--;
                if (run_left[i] == 0) begin
                    b[i] = ~b[i];
                    run_left[i] = $urandom_range(1, 20);
                end
            end
            step(b, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
